stage2_window_gen: RTL and testbench
====================================

# stage2_window_gen

Stage-2 sliding-window generator. It takes the stage-1 feature map as a raster-order pixel stream, one 20-bit signed value per valid cycle. It buffers KY-1 rows and emits a flattened KX×KY window for every valid (stride-1, no-padding) convolution position. The output feeds the stage-2 convolution kernel's fmap/valid inputs directly and uses the same element ordering that kernel expects.

## Interface
Parameters:
- IMG_W, 12: input feature-map width in pixels
- IMG_H, 12: input feature-map height in pixels
- KX, 5: window width
- KY, 5: window height
- IBW, 20: pixel bit width; equals the stage-2 conv input width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_in_valid  in  1  pixel strobe; one pixel is accepted per high cycle
- i_in_fmap  in  IBW  signed pixel, raster order (row-major, col 0 first)
- o_ot_valid  out  1  window strobe, one-cycle pulse per window
- o_ot_window  out  KX*KY*IBW  flattened signed window
- o_frame_done  out  1  present only with STAGE2_WIN_DONE_EN

## Operation
- Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) advance only on i_in_valid.
  - col wraps to 0 at IMG_W-1 and increments row.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0. The next frame starts on the next valid pixel with no bubble.
- KY-1 row delay lines, each IMG_W deep, shift only on i_in_valid. Row-delay k outputs the pixel at (row-k, col).
- The 5×5 window register is a shift array. On each valid pixel, every window row shifts left by one column. Column KX-1 loads the current column: rows r-4..r come from delays 4..1 plus the live pixel.
- Ordering: element index j*KX+i (slice [(j*KX+i)*IBW +: IBW]) holds pixel (r-(KY-1)+j, c-(KX-1)+i), where (r,c) is the pixel just accepted. Index 0 is top-left and index 24 is bottom-right.
- FSM, two states:
  - S_FILL: row < KY-1; no output. Moves to S_RUN when a pixel is accepted at row KY-1, col 0.
  - S_RUN: emits a window for each accepted pixel with col ≥ KX-1. Returns to S_FILL on the frame-wrap pixel.
- Windows per frame: (IMG_W-KX+1)*(IMG_H-KY+1), which is 64 at the defaults. Positions that would span a row boundary (col < KX-1) are never emitted.
- No backpressure. The consumer must accept every o_ot_valid pulse.
- Gaps in i_in_valid freeze all counters, delay lines, window contents and the FSM.
- Reset mid-frame: counters go to 0, FSM goes to S_FILL, and outputs go to 0. Delay-line contents need not be cleared, because they are overwritten before any window uses them.
- No arithmetic is performed; pixels pass through bit-exact, with sign preserved.

## Timing
- Reset values: o_ot_valid=0, o_ot_window=0, o_frame_done=0, row=col=0, state S_FILL.
- Latency: o_ot_valid and o_ot_window are registered, one cycle after the clk edge that accepts the completing pixel.
- o_ot_window holds its value until the next emitted window. Downstream samples it only when o_ot_valid=1.
- First window of a frame appears after pixel index (KY-1)*IMG_W+(KX-1), which is 52 at the defaults. The last window appears after pixel IMG_W*IMG_H-1.
- Throughput: one window per cycle during back-to-back valid input in S_RUN.
- A frame-wrap pixel and the first pixel of the next frame on consecutive cycles are legal. The last window of frame N is unaffected.

## Configuration
- STAGE2_WIN_DONE_EN
  - Defined: adds the o_frame_done port, a one-cycle pulse aligned with the final window of each frame (same cycle as its o_ot_valid).
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package/defines: KX, KY, ST2_Conv_IBW (used as IBW), stage-2 input map dimensions, and FSM state encodings S_FILL/S_RUN.
- Sub-module stage2_line_buffer: an IMG_W-deep, IBW-wide shift-enable delay line with ports clk, reset, i_en, i_data, o_data. It is instantiated KY-1 times.

## Test plan
- Default params, one frame of 144 pixels with pixel value = row*16+col, continuous valid:
  - exactly 64 o_ot_valid pulses;
  - first pulse 1 cycle after pixel 52, with window[0]=0x00, window[12]=0x22, window[24]=0x44;
  - last window has window[0]=0x77 and window[24]=0xBB.
- Same frame with i_in_valid randomly low 50% of cycles: windows are identical in content and order to the continuous case, and no pulse occurs during gaps.
- Two frames back-to-back, where frame 2 uses value+0x100:
  - 128 windows total;
  - frame-2 first window has window[0]=0x100;
  - no frame-1 pixel appears in any frame-2 window.
- Negative pixels (-1, i.e. 20'hFFFFF, at (6,6)): the bit-exact value appears at the expected slice of every window containing that position.
- Assert reset after 70 pixels, then send a full fresh frame: outputs are 0 during reset, and exactly 64 correct windows follow, with the first one after fresh pixel 52.
- With STAGE2_WIN_DONE_EN defined: o_frame_done pulses once per frame, coincident with the 64th o_ot_valid. Without it, the build elaborates with no o_frame_done port.

Source files
------------

// File: rtl/stage2_window_gen_pkg.sv
// Shared constants and FSM encoding for the stage-2 sliding-window generator.
package stage2_window_gen_pkg;

  localparam int KX           = 5;
  localparam int KY           = 5;
  localparam int ST2_Conv_IBW = 20;
  localparam int ST2_IMG_W    = 12;
  localparam int ST2_IMG_H    = 12;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } win_state_e;

endpackage

// File: rtl/stage2_window_gen_line_buffer.sv
// One-row delay line: a shift-enabled register chain IMG_W entries deep.
// The output is the pixel accepted IMG_W enabled cycles earlier.
module stage2_line_buffer #(
  parameter int IMG_W = 12,
  parameter int IBW   = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_en,
  input  logic [IBW-1:0] i_data,
  output logic [IBW-1:0] o_data
);

  logic [IBW-1:0] taps_q [IMG_W];
  logic [IBW-1:0] taps_d [IMG_W];

  always_comb begin
    taps_d = taps_q;
    if (i_en) begin
      taps_d[0] = i_data;
      for (int k = 1; k < IMG_W; k++) begin
        taps_d[k] = taps_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < IMG_W; k++) begin
        taps_q[k] <= '0;
      end
    end else begin
      taps_q <= taps_d;
    end
  end

  assign o_data = taps_q[IMG_W-1];

endmodule

// File: rtl/stage2_window_gen.sv
// Stage-2 sliding-window generator: buffers KY-1 rows and emits a flattened
// KX x KY window per valid convolution position. Optional o_frame_done port
// is enabled by defining STAGE2_WIN_DONE_EN.
//
// state  | meaning
// S_FILL | rows 0..KY-2 of a frame arriving, no windows possible
// S_RUN  | rows KY-1.. arriving, window emitted for every col >= KX-1
module stage2_window_gen #(
  parameter int IMG_W = stage2_window_gen_pkg::ST2_IMG_W,
  parameter int IMG_H = stage2_window_gen_pkg::ST2_IMG_H,
  parameter int KX    = stage2_window_gen_pkg::KX,
  parameter int KY    = stage2_window_gen_pkg::KY,
  parameter int IBW   = stage2_window_gen_pkg::ST2_Conv_IBW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_in_valid,
  input  logic [IBW-1:0]         i_in_fmap,
  output logic                   o_ot_valid,
  output logic [KX*KY*IBW-1:0]   o_ot_window
`ifdef STAGE2_WIN_DONE_EN
  ,
  output logic                   o_frame_done
`endif
);

  import stage2_window_gen_pkg::*;

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(KY - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  win_state_e    state_q, state_d;

  logic          frame_last;
  logic          emit;

  logic [IBW-1:0] line_tap [KY];
  logic [IBW-1:0] win_q [KY][KX];
  logic [IBW-1:0] win_d [KY][KX];
  logic [KX*KY*IBW-1:0] win_flat;

  logic                 valid_q, valid_d;
  logic [KX*KY*IBW-1:0] window_q, window_d;

  // ---------------- position counters ----------------
  assign frame_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: if (i_in_valid && (row_q == ROW_FIRST) && (col_q == '0)) state_d = S_RUN;
      S_RUN:  if (i_in_valid && frame_last) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    emit = 1'b0;
    if (state_q == S_RUN) begin
      emit = i_in_valid && (col_q >= COL_FIRST);
    end
  end

  // ---------------- row delay lines ----------------
  // line_tap[k] presents pixel (row-k, col) while the live pixel is on the input
  assign line_tap[0] = i_in_fmap;

  for (genvar k = 1; k < KY; k++) begin : g_line
    stage2_line_buffer #(
      .IMG_W (IMG_W),
      .IBW   (IBW)
    ) u_line (
      .clk    (clk),
      .reset  (reset),
      .i_en   (i_in_valid),
      .i_data (line_tap[k-1]),
      .o_data (line_tap[k])
    );
  end

  // ---------------- window shift array ----------------
  always_comb begin
    win_d = win_q;
    if (i_in_valid) begin
      for (int j = 0; j < KY; j++) begin
        for (int i = 0; i < KX - 1; i++) begin
          win_d[j][i] = win_q[j][i+1];
        end
        win_d[j][KX-1] = line_tap[KY-1-j];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < KY; j++) begin
        for (int i = 0; i < KX; i++) begin
          win_q[j][i] <= '0;
        end
      end
    end else begin
      win_q <= win_d;
    end
  end

  // Output is taken from the post-shift array so the window lands one edge after its pixel
  always_comb begin
    win_flat = '0;
    for (int j = 0; j < KY; j++) begin
      for (int i = 0; i < KX; i++) begin
        win_flat[(j*KX+i)*IBW +: IBW] = win_d[j][i];
      end
    end
  end

  // ---------------- registered outputs ----------------
  always_comb begin
    valid_d  = emit;
    window_d = emit ? win_flat : window_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      window_q <= '0;
    end else begin
      valid_q  <= valid_d;
      window_q <= window_d;
    end
  end

  assign o_ot_valid  = valid_q;
  assign o_ot_window = window_q;

`ifdef STAGE2_WIN_DONE_EN
  logic done_q, done_d;

  always_comb begin
    done_d = emit && frame_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign o_frame_done = done_q;
`endif

endmodule

// File: tb/tb_stage2_window_gen.sv
// Directed self-checking bench for stage2_window_gen (default 12x12, 5x5 window).
// Define STAGE2_WIN_DONE_EN to also exercise o_frame_done.
module tb_stage2_window_gen;

  localparam int W    = 12;
  localparam int H    = 12;
  localparam int KXT  = 5;
  localparam int KYT  = 5;
  localparam int IB   = 20;
  localparam int NWIN = (W - KXT + 1) * (H - KYT + 1);
  localparam int WBITS = KXT * KYT * IB;

  logic             clk;
  logic             reset;
  logic             i_in_valid;
  logic [IB-1:0]    i_in_fmap;
  logic             o_ot_valid;
  logic [WBITS-1:0] o_ot_window;
`ifdef STAGE2_WIN_DONE_EN
  logic             o_frame_done;
  int               done_at[$];
`endif

  int checks = 0;
  int errors = 0;

  logic [WBITS-1:0] wins[$];
  int               pix_at[$];
  int               acc_cnt;
  int               gap_pulses;

  stage2_window_gen #(
    .IMG_W (W),
    .IMG_H (H),
    .KX    (KXT),
    .KY    (KYT),
    .IBW   (IB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (i_in_valid),
    .i_in_fmap   (i_in_fmap),
    .o_ot_valid  (o_ot_valid),
    .o_ot_window (o_ot_window)
`ifdef STAGE2_WIN_DONE_EN
    ,
    .o_frame_done(o_frame_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IB-1:0] pix(input int r, input int c, input logic [IB-1:0] base, input bit neg);
    if (neg && r == 6 && c == 6) return 20'hFFFFF;
    return base + IB'(r * 16 + c);
  endfunction

  function automatic logic [WBITS-1:0] exp_window(input int r, input int c, input logic [IB-1:0] base, input bit neg);
    logic [WBITS-1:0] w;
    w = '0;
    for (int j = 0; j < KYT; j++)
      for (int i = 0; i < KXT; i++)
        w[(j*KXT+i)*IB +: IB] = pix(r - (KYT-1) + j, c - (KXT-1) + i, base, neg);
    return w;
  endfunction

  function automatic logic [IB-1:0] elem(input logic [WBITS-1:0] w, input int k);
    return w[k*IB +: IB];
  endfunction

  // Drive one cycle, then sample #1 after the edge.
  task automatic step(input logic v, input logic [IB-1:0] d);
    i_in_valid = v;
    i_in_fmap  = d;
    @(posedge clk);
    #1;
    if (v && !reset) acc_cnt++;
    if (o_ot_valid) begin
      wins.push_back(o_ot_window);
      pix_at.push_back(acc_cnt - 1);
      if (!v) gap_pulses++;
    end
`ifdef STAGE2_WIN_DONE_EN
    if (o_frame_done) done_at.push_back(wins.size());
`endif
  endtask

  task automatic clear_capture();
    wins.delete();
    pix_at.delete();
    acc_cnt    = 0;
    gap_pulses = 0;
`ifdef STAGE2_WIN_DONE_EN
    done_at.delete();
`endif
  endtask

  task automatic send_frame(input logic [IB-1:0] base, input bit neg, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps) while ($urandom_range(0, 1) == 1) step(1'b0, 20'hABCDE);
        step(1'b1, pix(r, c, base, neg));
      end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    i_in_valid = 1'b0;
    i_in_fmap  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (o_ot_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_ot_valid); end
    checks++;
    if (o_ot_window !== '0) begin errors++; $display("FAIL reset_window got %h exp 0", o_ot_window); end
`ifdef STAGE2_WIN_DONE_EN
    checks++;
    if (o_frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_frame_done); end
`endif
    reset = 1'b0;
    clear_capture();
  endtask

  task automatic test_continuous();
    clear_capture();
    send_frame(20'h0, 1'b0, 1'b0);
    repeat (4) step(1'b0, 20'h5A5A5);
    checks++;
    if (wins.size() != NWIN) begin errors++; $display("FAIL cont_count got %0d exp %0d", wins.size(), NWIN); end
    if (wins.size() >= NWIN) begin
      checks++;
      if (pix_at[0] != 52) begin errors++; $display("FAIL cont_first_pix got %0d exp 52", pix_at[0]); end
      checks++;
      if (elem(wins[0], 0) !== 20'h00) begin errors++; $display("FAIL cont_first_e0 got %h exp 00", elem(wins[0], 0)); end
      checks++;
      if (elem(wins[0], 12) !== 20'h22) begin errors++; $display("FAIL cont_first_e12 got %h exp 22", elem(wins[0], 12)); end
      checks++;
      if (elem(wins[0], 24) !== 20'h44) begin errors++; $display("FAIL cont_first_e24 got %h exp 44", elem(wins[0], 24)); end
      checks++;
      if (elem(wins[NWIN-1], 0) !== 20'h77) begin errors++; $display("FAIL cont_last_e0 got %h exp 77", elem(wins[NWIN-1], 0)); end
      checks++;
      if (elem(wins[NWIN-1], 24) !== 20'hBB) begin errors++; $display("FAIL cont_last_e24 got %h exp BB", elem(wins[NWIN-1], 24)); end
      for (int k = 0; k < NWIN; k++) begin
        int r, c;
        r = KYT - 1 + k / (W - KXT + 1);
        c = KXT - 1 + k % (W - KXT + 1);
        checks++;
        if (wins[k] !== exp_window(r, c, 20'h0, 1'b0) || pix_at[k] != r * W + c) begin
          errors++;
          $display("FAIL cont_win[%0d] got %h at pix %0d exp %h at pix %0d", k, wins[k], pix_at[k], exp_window(r, c, 20'h0, 1'b0), r * W + c);
        end
      end
    end
    checks++;
    if (o_ot_window !== exp_window(11, 11, 20'h0, 1'b0)) begin
      errors++; $display("FAIL cont_hold got %h exp %h", o_ot_window, exp_window(11, 11, 20'h0, 1'b0));
    end
`ifdef STAGE2_WIN_DONE_EN
    checks++;
    if (done_at.size() != 1 || (done_at.size() == 1 && done_at[0] != NWIN)) begin
      errors++; $display("FAIL cont_frame_done pulses %0d exp 1 at window %0d", done_at.size(), NWIN);
    end
`endif
  endtask

  task automatic test_gaps();
    clear_capture();
    send_frame(20'h0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 20'h13579);
    checks++;
    if (wins.size() != NWIN) begin errors++; $display("FAIL gap_count got %0d exp %0d", wins.size(), NWIN); end
    checks++;
    if (gap_pulses != 0) begin errors++; $display("FAIL gap_pulse_in_gap got %0d exp 0", gap_pulses); end
    if (wins.size() >= NWIN) begin
      for (int k = 0; k < NWIN; k++) begin
        int r, c;
        r = KYT - 1 + k / (W - KXT + 1);
        c = KXT - 1 + k % (W - KXT + 1);
        checks++;
        if (wins[k] !== exp_window(r, c, 20'h0, 1'b0)) begin
          errors++; $display("FAIL gap_win[%0d] got %h exp %h", k, wins[k], exp_window(r, c, 20'h0, 1'b0));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_capture();
    send_frame(20'h0, 1'b0, 1'b0);
    send_frame(20'h100, 1'b0, 1'b0);
    repeat (2) step(1'b0, 20'h0);
    checks++;
    if (wins.size() != 2 * NWIN) begin errors++; $display("FAIL b2b_count got %0d exp %0d", wins.size(), 2 * NWIN); end
    if (wins.size() >= 2 * NWIN) begin
      checks++;
      if (elem(wins[NWIN], 0) !== 20'h100) begin errors++; $display("FAIL b2b_f2_first_e0 got %h exp 100", elem(wins[NWIN], 0)); end
      checks++;
      if (pix_at[NWIN] != W * H + 52) begin errors++; $display("FAIL b2b_f2_first_pix got %0d exp %0d", pix_at[NWIN], W * H + 52); end
      checks++;
      if (wins[NWIN-1] !== exp_window(11, 11, 20'h0, 1'b0)) begin
        errors++; $display("FAIL b2b_f1_last got %h exp %h", wins[NWIN-1], exp_window(11, 11, 20'h0, 1'b0));
      end
      for (int k = 0; k < NWIN; k++) begin
        int r, c;
        bit stale;
        r = KYT - 1 + k / (W - KXT + 1);
        c = KXT - 1 + k % (W - KXT + 1);
        stale = 1'b0;
        for (int e = 0; e < KXT * KYT; e++)
          if (elem(wins[NWIN+k], e) < 20'h100) stale = 1'b1;
        checks++;
        if (stale || wins[NWIN+k] !== exp_window(r, c, 20'h100, 1'b0)) begin
          errors++; $display("FAIL b2b_f2_win[%0d] got %h exp %h", k, wins[NWIN+k], exp_window(r, c, 20'h100, 1'b0));
        end
      end
    end
`ifdef STAGE2_WIN_DONE_EN
    checks++;
    if (done_at.size() != 2 || (done_at.size() == 2 && (done_at[0] != NWIN || done_at[1] != 2 * NWIN))) begin
      errors++; $display("FAIL b2b_frame_done pulses %0d exp 2 at windows %0d,%0d", done_at.size(), NWIN, 2 * NWIN);
    end
`endif
  endtask

  task automatic test_negative();
    int hits;
    clear_capture();
    send_frame(20'h0, 1'b1, 1'b0);
    step(1'b0, 20'h0);
    hits = 0;
    checks++;
    if (wins.size() != NWIN) begin errors++; $display("FAIL neg_count got %0d exp %0d", wins.size(), NWIN); end
    if (wins.size() >= NWIN) begin
      for (int k = 0; k < NWIN; k++) begin
        int r, c;
        r = KYT - 1 + k / (W - KXT + 1);
        c = KXT - 1 + k % (W - KXT + 1);
        checks++;
        if (wins[k] !== exp_window(r, c, 20'h0, 1'b1)) begin
          errors++; $display("FAIL neg_win[%0d] got %h exp %h", k, wins[k], exp_window(r, c, 20'h0, 1'b1));
        end
        if (r >= 6 && r <= 10 && c >= 6 && c <= 10) begin
          int idx;
          idx = (6 - (r - 4)) * KXT + (6 - (c - 4));
          hits++;
          checks++;
          if (elem(wins[k], idx) !== 20'hFFFFF) begin
            errors++; $display("FAIL neg_slice win %0d idx %0d got %h exp FFFFF", k, idx, elem(wins[k], idx));
          end
        end
      end
      checks++;
      if (hits != 25) begin errors++; $display("FAIL neg_hits got %0d exp 25", hits); end
    end
  endtask

  task automatic test_reset_midframe();
    clear_capture();
    for (int p = 0; p < 70; p++) step(1'b1, pix(p / W, p % W, 20'h0, 1'b0));
    reset = 1'b1;
    #1;
    checks++;
    if (o_ot_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b exp 0", o_ot_valid); end
    checks++;
    if (o_ot_window !== '0) begin errors++; $display("FAIL rst_mid_window got %h exp 0", o_ot_window); end
    for (int n = 0; n < 2; n++) begin
      step(1'b1, 20'h12345);
      checks++;
      if (o_ot_valid !== 1'b0 || o_ot_window !== '0) begin
        errors++; $display("FAIL rst_mid_hold valid %b window %h exp 0", o_ot_valid, o_ot_window);
      end
    end
    reset = 1'b0;
    clear_capture();
    send_frame(20'h200, 1'b0, 1'b0);
    step(1'b0, 20'h0);
    checks++;
    if (wins.size() != NWIN) begin errors++; $display("FAIL rst_fresh_count got %0d exp %0d", wins.size(), NWIN); end
    if (wins.size() >= NWIN) begin
      checks++;
      if (pix_at[0] != 52) begin errors++; $display("FAIL rst_fresh_first_pix got %0d exp 52", pix_at[0]); end
      for (int k = 0; k < NWIN; k++) begin
        int r, c;
        r = KYT - 1 + k / (W - KXT + 1);
        c = KXT - 1 + k % (W - KXT + 1);
        checks++;
        if (wins[k] !== exp_window(r, c, 20'h200, 1'b0)) begin
          errors++; $display("FAIL rst_fresh_win[%0d] got %h exp %h", k, wins[k], exp_window(r, c, 20'h200, 1'b0));
        end
      end
    end
  endtask

  initial begin
    void'($urandom(32'h5EED_0002));
    reset      = 1'b1;
    i_in_valid = 1'b0;
    i_in_fmap  = '0;
    acc_cnt    = 0;
    gap_pulses = 0;
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_negative();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
